// File: rtl/coax_receiver.sv
// Receive-side bit engine for the 3270 coax link: decodes Manchester frames from rx
// and queues each {parity mismatch, data} word in a small FIFO for the host side.
module coax_receiver #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DEPTH          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       parity_error,
    output logic       data_available,
    input  logic       data_read,
    output logic       overflow
);

    localparam int TW = $clog2(2 * CLOCKS_PER_BIT) + 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [TW-1:0] TMR_MAX     = '1;
    localparam logic [TW-1:0] H_MIN       = TW'(CLOCKS_PER_BIT / 2 - CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] H_MAX       = TW'(CLOCKS_PER_BIT / 2 + CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] CV_MIN      = TW'(3 * (CLOCKS_PER_BIT / 2) - CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] CV_MAX      = TW'(3 * (CLOCKS_PER_BIT / 2) + CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] MID_MIN     = TW'(3 * CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] MID_MAX     = TW'(5 * CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] SYNC_PRESET = TW'(CLOCKS_PER_BIT / 2 - CLOCKS_PER_BIT / 4 + 1);
    localparam logic [AW:0]   DEPTH_CNT   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CV_HIGH,
        S_SYNC,
        S_DATA,
        S_PARITY,
        S_END
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rx_meta_d;
    logic           rx_sync_q, rx_sync_d;
    logic           rx_prev_q, rx_prev_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [2:0]     ones_q, ones_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [9:0]     shift_q, shift_d;
    logic           enq_q, enq_d;
    logic [10:0]    enq_word_q, enq_word_d;

    logic [10:0]    mem_q [DEPTH];
    logic [10:0]    mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           data_read_q, data_read_d;

    logic line_edge, mid_edge, timeout, in_half, in_cv;
    logic pop, push, full;

    assign line_edge = rx_sync_q ^ rx_prev_q;
    assign mid_edge  = line_edge && (tmr_q >= MID_MIN);
    assign timeout   = !line_edge && (tmr_q > MID_MAX);
    assign in_half   = (tmr_q >= H_MIN) && (tmr_q <= H_MAX);
    assign in_cv     = (tmr_q >= CV_MIN) && (tmr_q <= CV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b0;
            rx_sync_q   <= 1'b0;
            rx_prev_q   <= 1'b0;
            tmr_q       <= '0;
            ones_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            enq_q       <= 1'b0;
            enq_word_q  <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            data_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            tmr_q       <= tmr_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            enq_q       <= enq_d;
            enq_word_q  <= enq_word_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            data_read_q <= data_read_d;
        end
    end

    // Outside the bit-decoding states the timer measures run lengths; inside them
    // it restarts only on mid-cell transitions, and the bit is the pre-edge level.
    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        state_d    = state_q;
        tmr_d      = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        enq_d      = 1'b0;
        enq_word_d = enq_word_q;
        if (line_edge && !(state_q inside {S_SYNC, S_DATA, S_PARITY})) begin
            tmr_d = 1;
        end
        case (state_q)
            S_IDLE: begin
                if (line_edge && rx_sync_q) begin
                    state_d = S_START;
                    ones_d  = '0;
                end
            end
            S_START: begin
                if (line_edge) begin
                    if (!rx_sync_q) begin
                        if (in_half) begin
                            ones_d = (ones_q == 3'd5) ? ones_q : ones_q + 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (!in_half) begin
                        state_d = (in_cv && ones_q == 3'd5) ? S_CV_HIGH : S_IDLE;
                    end
                end else if (tmr_q > CV_MAX) begin
                    state_d = S_IDLE;
                end
            end
            S_CV_HIGH: begin
                // Preset the timer as if a mid-cell edge occurred half a cell before the sync cell.
                if (line_edge) begin
                    state_d = S_IDLE;
                end else if (tmr_q == CV_MIN) begin
                    state_d = S_SYNC;
                    tmr_d   = SYNC_PRESET;
                end
            end
            S_SYNC: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (mid_edge) begin
                    tmr_d     = 1;
                    bit_cnt_d = '0;
                    state_d   = rx_prev_q ? S_DATA : S_END;
                end
            end
            S_DATA: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (mid_edge) begin
                    tmr_d   = 1;
                    shift_d = {shift_q[8:0], rx_prev_q};
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (mid_edge) begin
                    tmr_d      = 1;
                    enq_d      = 1'b1;
                    enq_word_d = {(^shift_q) ^ rx_prev_q, shift_q};
                    state_d    = S_SYNC;
                end
            end
            S_END: begin
                if (!rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a coincident word.
    always_comb begin
        data_read_d = data_read;
        pop         = data_read && !data_read_q && (count_q != '0);
        full        = (count_q == DEPTH_CNT);
        push        = enq_q && (!full || pop);
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (enq_q && full && !pop);
        if (push) begin
            mem_d[wr_ptr_q] = enq_word_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        active         = (state_q != S_IDLE);
        data_available = (count_q != '0);
        overflow       = overflow_q;
        data           = '0;
        parity_error   = 1'b0;
        if (count_q != '0) begin
            {parity_error, data} = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_coax_receiver.sv
// Directed bench for coax_receiver: hand-encodes Manchester frames onto rx and checks
// the queued words, parity flags, overflow and pop behaviour with immediate assertions.
module tb_coax_receiver;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       data_read;
    logic       active;
    logic [9:0] data;
    logic       parity_error;
    logic       data_available;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    coax_receiver #(
        .CLOCKS_PER_BIT(CPB),
        .DEPTH         (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .active        (active),
        .data          (data),
        .parity_error  (parity_error),
        .data_available(data_available),
        .data_read     (data_read),
        .overflow      (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int halves);
        rx = level;
        repeat (halves * HALF) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(b, 1);
        applyStimulus(!b, 1);
    endtask

    task automatic sendStart();
        repeat (4) sendBit(1'b1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 3);
    endtask

    task automatic sendWord(input logic [9:0] w, input logic flip);
        sendBit(1'b1);
        for (int i = 9; i >= 0; i--) sendBit(w[i]);
        sendBit((^w) ^ flip);
    endtask

    // Raises data_read so its rising edge lands on the cycle this word is enqueued.
    task automatic sendWordPop(input logic [9:0] w);
        logic p;
        p = ^w;
        sendBit(1'b1);
        for (int i = 9; i >= 0; i--) sendBit(w[i]);
        applyStimulus(p, 1);
        rx = !p;
        repeat (3) @(negedge clk);
        data_read = 1'b1;
        repeat (HALF - 3) @(negedge clk);
        data_read = 1'b0;
    endtask

    task automatic sendEnd();
        sendBit(1'b0);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pulseRead(input int cycles);
        data_read = 1'b1;
        repeat (cycles) @(negedge clk);
        data_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        rx        = 1'b0;
        data_read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        rx        = 1'b0;
        data_read = 1'b0;
        @(negedge clk);
        doReset();

        $display("[TB] reset and idle line");
        repeat (100) @(negedge clk);
        checkOutput("idle_active", active, 0);
        checkOutput("idle_avail", data_available, 0);
        checkOutput("idle_overflow", overflow, 0);
        checkOutput("idle_data", data, 0);
        checkOutput("idle_perr", parity_error, 0);

        $display("[TB] two-word frame");
        sendStart();
        checkOutput("frame_active", active, 1);
        sendWord(10'h005, 1'b0);
        sendWord(10'h3FF, 1'b0);
        sendEnd();
        checkOutput("f1_avail", data_available, 1);
        checkOutput("f1_data", data, 10'h005);
        checkOutput("f1_perr", parity_error, 0);
        checkOutput("f1_active_end", active, 0);

        $display("[TB] held data_read pops once");
        repeat (200) @(negedge clk);
        pulseRead(2);
        checkOutput("pop1_data", data, 10'h3FF);
        checkOutput("pop1_perr", parity_error, 0);
        checkOutput("pop1_avail", data_available, 1);
        repeat (100) @(negedge clk);
        pulseRead(1);
        checkOutput("pop2_avail", data_available, 0);
        pulseRead(1);
        checkOutput("empty_pop_avail", data_available, 0);
        checkOutput("empty_pop_overflow", overflow, 0);

        $display("[TB] flipped parity");
        sendStart();
        sendWord(10'h2AA, 1'b1);
        sendEnd();
        checkOutput("par_avail", data_available, 1);
        checkOutput("par_data", data, 10'h2AA);
        checkOutput("par_perr", parity_error, 1);
        checkOutput("par_active_end", active, 0);
        pulseRead(1);
        checkOutput("par_drain_avail", data_available, 0);

        $display("[TB] overflow with DEPTH+1 words");
        sendStart();
        sendWord(10'h001, 1'b0);
        sendWord(10'h002, 1'b0);
        sendWord(10'h004, 1'b0);
        sendWord(10'h008, 1'b0);
        sendWord(10'h010, 1'b0);
        sendEnd();
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_head0", data, 10'h001);
        pulseRead(1);
        checkOutput("ovf_head1", data, 10'h002);
        pulseRead(1);
        checkOutput("ovf_head2", data, 10'h004);
        pulseRead(1);
        checkOutput("ovf_head3", data, 10'h008);
        pulseRead(1);
        checkOutput("ovf_empty", data_available, 0);
        checkOutput("ovf_sticky", overflow, 1);

        $display("[TB] pop coincident with enqueue into full FIFO");
        doReset();
        checkOutput("rst_ovf_clear", overflow, 0);
        sendStart();
        sendWord(10'h011, 1'b0);
        sendWord(10'h022, 1'b0);
        sendWord(10'h044, 1'b0);
        sendWord(10'h088, 1'b0);
        sendWordPop(10'h100);
        sendEnd();
        checkOutput("sim_overflow", overflow, 0);
        checkOutput("sim_head0", data, 10'h022);
        pulseRead(1);
        checkOutput("sim_head1", data, 10'h044);
        pulseRead(1);
        checkOutput("sim_head2", data, 10'h088);
        pulseRead(1);
        checkOutput("sim_head3", data, 10'h100);
        pulseRead(1);
        checkOutput("sim_empty", data_available, 0);

        $display("[TB] reset mid-frame");
        sendStart();
        sendWord(10'h0F0, 1'b0);
        sendEnd();
        checkOutput("pre_rst_avail", data_available, 1);
        sendStart();
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("mid_active", active, 1);
        reset = 1'b1;
        rx    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mrst_active", active, 0);
        checkOutput("mrst_avail", data_available, 0);
        checkOutput("mrst_data", data, 0);
        checkOutput("mrst_perr", parity_error, 0);
        checkOutput("mrst_overflow", overflow, 0);
        repeat (20) @(negedge clk);
        sendStart();
        sendWord(10'h155, 1'b0);
        sendEnd();
        checkOutput("post_avail", data_available, 1);
        checkOutput("post_data", data, 10'h155);
        checkOutput("post_perr", parity_error, 0);
        checkOutput("post_active", active, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
